s_detector_1010: RTL and testbench
==================================

// Module: s_detector_1010
// PURPOSE
//   Mealy finite-state machine that detects the serial bit pattern 1-0-1-0 on input x.
//   One bit is sampled per rising clock edge.
//   Output z asserts combinationally during the cycle in which the final '0' of the
//   pattern is present on x.
//   Overlapping detection is the default: the trailing "10" of a match seeds the next match.
//   Used as a small stream-pattern flag inside serial-protocol front ends.
// PARAMETERS
//   OVERLAP   1   1 = overlapping detection (1010 -> trailing "10" reused); 0 = non-overlapping
// PORTS
//   clk    in  1  single clock; all state updates on rising edge
//   reset  in  1  asynchronous, active-low reset (0 = reset asserted)
//   x      in  1  serial data bit, sampled on rising clk
//   z      out 1  Mealy match flag; high when state==S3 and x==0
// BEHAVIOUR
//   - States (2-bit encoding):
//       S0 = idle / no prefix
//       S1 = seen "1"
//       S2 = seen "10"
//       S3 = seen "101"
//   - Reset: reset==0 forces state=S0 immediately, without waiting for clk.
//     z is therefore 0 while reset is held low.
//     State leaves S0 only on the first rising clk after reset returns to 1.
//   - Transitions on rising clk (current state, x -> next state):
//       S0: x=1 -> S1; x=0 -> S0
//       S1: x=1 -> S1; x=0 -> S2
//       S2: x=1 -> S3; x=0 -> S0
//       S3: x=1 -> S1; x=0 -> S2 when OVERLAP=1, S0 when OVERLAP=0
//   - Output: z = (state==S3) & ~x. It is purely combinational from the registered state and x.
//     z responds to x within the same cycle, with zero-cycle latency.
//     z is valid for the setup window before the edge that consumes the final '0'.
//   - A glitch on x while in S3 may glitch z; downstream logic must sample z on clk.
//   - Illegal or unknown state encodings recover to S0 on the next clock edge; z=0 in them.
//   - Reset asserted mid-sequence discards all partial progress; the pattern must restart.
//   - The "11" prefix is retained: S1 with x=1 stays in S1, so "11010" matches.
//   - No other outputs. No enable input: every edge consumes a bit.
// TESTING
//   - Reset: hold reset=0 and toggle x -> state stays S0 and z=0 throughout.
//     Release reset -> first match possible only after 4 sampled bits.
//   - Single match: x=1,0,1,0 on 4 consecutive edges -> z=1 only while the 4th bit (0)
//     is on x; z=0 in all other cycles.
//   - Overlap (OVERLAP=1): x=1,0,1,0,1,0,1,0 -> z pulses 3 times, on bits 4, 6 and 8.
//   - Non-overlap (OVERLAP=0): same stream -> z pulses twice, on bits 4 and 8.
//   - Near-misses: x=1,1,0,1,0 -> one pulse, on the last bit.
//     x=1,0,0,1,0 -> no pulse.
//     x=1,0,1,1,0 -> no pulse (after "1011", "0" goes S1->S2).
//   - Async reset: drive 1,0,1, then pulse reset=0 between edges -> state returns to S0 at once.
//     A following x=0 gives z=0; a new 1,0,1,0 is then required for a match.

Source files
------------

// File: rtl/s_detector_1010.sv
// Serial 1-0-1-0 pattern detector: a Mealy FSM whose match flag z rises in the same
// cycle that the final '0' is on x, with optional overlapping detection.
module s_detector_1010 #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0 = 2'd0,  // idle / no prefix
    S1 = 2'd1,  // seen "1"
    S2 = 2'd2,  // seen "10"
    S3 = 2'd3   // seen "101"
  } state_e;

  state_e state_q, state_d;

  // State register; a low reset clears all partial progress without waiting for clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the combinational Mealy match flag
  always_comb begin
    state_d = S0;
    z       = 1'b0;
    case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S1 : S2;
      S2: state_d = x ? S3 : S0;
      S3: begin
        if (x) begin
          state_d = S1;
        end else begin
          // The trailing "10" of a match can seed the next one
          state_d = OVERLAP ? S2 : S0;
          z       = 1'b1;
        end
      end
      default: begin
        state_d = S0;
        z       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_s_detector_1010.sv
// Directed-vector bench for s_detector_1010, running an overlapping and a
// non-overlapping instance side by side on the same serial stream.
module tb_s_detector_1010;

  logic clk;
  logic reset;
  logic x;
  logic z_ov;
  logic z_no;

  int unsigned n_vec;
  int unsigned n_err;

  s_detector_1010 #(.OVERLAP(1'b1)) u_dut_ov (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .z     (z_ov)
  );

  s_detector_1010 #(.OVERLAP(1'b0)) u_dut_no (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .z     (z_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one bit mid-cycle, check both flags, then let the next edge consume it
  task automatic step(input string tag, input logic b, input logic e_ov, input logic e_no);
    x = b;
    #2;
    chk({tag, "/ov"}, z_ov, e_ov);
    chk({tag, "/no"}, z_no, e_no);
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse between edges, returning both FSMs to idle
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic run_seq(input string tag, input logic [15:0] bits, input int len,
                         input logic [15:0] e_ov, input logic [15:0] e_no);
    for (int i = 0; i < len; i++) begin
      step($sformatf("%s[%0d]", tag, i), bits[i], e_ov[i], e_no[i]);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    x     = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset: toggling x across edges (including a full 1010) never matches
    for (int i = 0; i < 4; i++) begin
      x = (i % 2 == 0);
      #2;
      chk($sformatf("rst_hold_x%0d/ov", i), z_ov, 1'b0);
      chk($sformatf("rst_hold_x%0d/no", i), z_no, 1'b0);
      @(posedge clk);
      #1;
    end
    x = 1'b0;
    #2;
    chk("rst_hold_last/ov", z_ov, 1'b0);
    chk("rst_hold_last/no", z_no, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single match: bits listed LSB first
    run_seq("single", 16'b0101, 4, 16'b1000, 16'b1000);

    // Overlap stream 10101010: overlap fires on 4,6,8; non-overlap on 4,8
    pulse_reset();
    run_seq("stream", 16'b0101_0101, 8, 16'b1010_1000, 16'b1000_1000);

    // "11010": retained 1 prefix, match on last bit
    pulse_reset();
    run_seq("11010", 16'b01011, 5, 16'b10000, 16'b10000);

    // "10010": no match
    pulse_reset();
    run_seq("10010", 16'b01001, 5, 16'b00000, 16'b00000);

    // "10110": no match
    pulse_reset();
    run_seq("10110", 16'b01101, 5, 16'b00000, 16'b00000);

    // Async reset mid-pattern: reach S3, show z live, then reset between edges
    pulse_reset();
    run_seq("pre_abort", 16'b101, 3, 16'b000, 16'b000);
    x = 1'b0;
    #1;
    chk("s3_live/ov", z_ov, 1'b1);
    chk("s3_live/no", z_no, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_low/ov", z_ov, 1'b0);
    chk("async_rst_low/no", z_no, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_rel/ov", z_ov, 1'b0);
    chk("async_rst_rel/no", z_no, 1'b0);
    @(posedge clk);
    #1;
    // Partial progress is gone: a fresh 1010 is needed
    run_seq("restart", 16'b0101, 4, 16'b1000, 16'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
